// File: rtl/mp3_play_ctrl.sv
// Play/track control for the VS1003 streamer: debounces the front-panel buttons and
// drives start, music_id and a timed active-low restart pulse for the streamer.
module mp3_play_ctrl #(
  parameter int NUM_TRACKS      = 8,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int RESTART_CYCLES  = 16,
  parameter int AUTO_NEXT       = 1
) (
  input  logic       clk_1M,
  input  logic       rst,
  input  logic       btn_play,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       track_end,
  output logic       start,
  output logic [2:0] music_id,
  output logic       player_rst_n,
  output logic [1:0] state_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(RESTART_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RESTART = 2'd1,
    ST_PLAYING = 2'd2,
    ST_PAUSED  = 2'd3
  } state_t;

  state_t        state;
  logic [RW-1:0] rcnt;

  // Button bit order: [0] play, [1] next, [2] prev.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1, sync2, db_lvl, db_dly, btn_ev;
  logic [DW-1:0] db_cnt [3];

  assign btn_raw = {btn_prev, btn_next, btn_play};

  always_ff @(posedge clk_1M) begin
    if (!rst) begin
      sync1  <= '0;
      sync2  <= '0;
      db_lvl <= '0;
      db_dly <= '0;
      btn_ev <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1  <= btn_raw;
      sync2  <= sync1;
      db_dly <= db_lvl;
      btn_ev <= db_lvl & ~db_dly;
      // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // track_end outranks buttons; a next+prev clash cancels both; a track event drops play.
  logic       btn_ok, go_next, go_prev, go_play, go_track;
  logic [2:0] id_inc, id_dec, id_upd;

  assign btn_ok   = ~track_end;
  assign go_next  = btn_ok & btn_ev[1] & ~btn_ev[2];
  assign go_prev  = btn_ok & btn_ev[2] & ~btn_ev[1];
  assign go_play  = btn_ok & btn_ev[0] & ~btn_ev[1] & ~btn_ev[2];
  assign go_track = go_next | go_prev;
  assign id_inc   = (music_id == 3'(NUM_TRACKS - 1)) ? 3'd0 : music_id + 3'd1;
  assign id_dec   = (music_id == 3'd0) ? 3'(NUM_TRACKS - 1) : music_id - 3'd1;
  assign id_upd   = go_next ? id_inc : id_dec;

  always_ff @(posedge clk_1M) begin
    if (!rst) begin
      state        <= ST_STOPPED;
      music_id     <= '0;
      start        <= 1'b0;
      player_rst_n <= 1'b1;
      rcnt         <= '0;
    end else begin
      case (state)
        ST_STOPPED: begin
          if (go_track) begin
            music_id <= id_upd;
          end else if (go_play) begin
            state        <= ST_RESTART;
            player_rst_n <= 1'b0;
            rcnt         <= '0;
          end
        end
        ST_RESTART: begin
          if (rcnt == RW'(RESTART_CYCLES - 1)) begin
            state        <= ST_PLAYING;
            player_rst_n <= 1'b1;
            start        <= 1'b1;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        ST_PLAYING: begin
          if (track_end) begin
            start <= 1'b0;
            if (AUTO_NEXT != 0) begin
              music_id     <= id_inc;
              state        <= ST_RESTART;
              player_rst_n <= 1'b0;
              rcnt         <= '0;
            end else begin
              state <= ST_STOPPED;
            end
          end else if (go_track) begin
            music_id     <= id_upd;
            state        <= ST_RESTART;
            player_rst_n <= 1'b0;
            start        <= 1'b0;
            rcnt         <= '0;
          end else if (go_play) begin
            state <= ST_PAUSED;
            start <= 1'b0;
          end
        end
        ST_PAUSED: begin
          if (go_track) begin
            music_id     <= id_upd;
            state        <= ST_RESTART;
            player_rst_n <= 1'b0;
            rcnt         <= '0;
          end else if (go_play) begin
            state <= ST_PLAYING;
            start <= 1'b1;
          end
        end
        default: state <= ST_STOPPED;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_mp3_play_ctrl.sv
// Bench for mp3_play_ctrl: directed scenarios plus a random press sequence checked
// against a press-level model of the player (state, track number, restart pulses).
module tb_mp3_play_ctrl;
  localparam int D = 4;
  localparam int R = 3;
  localparam int N = 8;

  logic       clk_1M = 1'b0;
  logic       rst = 1'b0;
  logic       btn_play = 1'b0, btn_next = 1'b0, btn_prev = 1'b0, track_end = 1'b0;
  logic       start, player_rst_n;
  logic [2:0] music_id;
  logic [1:0] state_o;

  int errors = 0;
  int checks = 0;
  int low_total = 0;   // cycles seen with player_rst_n low
  int viol = 0;        // player_rst_n low outside RESTART

  mp3_play_ctrl #(.NUM_TRACKS(N), .DEBOUNCE_CYCLES(D), .RESTART_CYCLES(R), .AUTO_NEXT(1)) dut (
    .clk_1M(clk_1M), .rst(rst), .btn_play(btn_play), .btn_next(btn_next),
    .btn_prev(btn_prev), .track_end(track_end), .start(start), .music_id(music_id),
    .player_rst_n(player_rst_n), .state_o(state_o)
  );

  always #500 clk_1M = ~clk_1M;

  always @(negedge clk_1M) begin
    if (!player_rst_n) begin
      low_total = low_total + 1;
      if (state_o != 2'd1) viol = viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_1M);
      #1;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_play = v;
      1: btn_next = v;
      default: btn_prev = v;
    endcase
  endtask

  // Clean press: hold, release, then let debounce and any restart settle.
  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick(10);
    set_btn(b, 1'b0);
    tick(20);
  endtask

  task automatic pulse_end();
    track_end = 1'b1;
    tick(1);
    track_end = 1'b0;
    tick(20);
  endtask

  task automatic chk_outs(input string tag, input int st, input int id, input int strt);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".id"}, 32'(music_id), 32'(id));
    chk({tag, ".start"}, 32'(start), 32'(strt));
    chk({tag, ".rst_n"}, 32'(player_rst_n), 32'd1);
  endtask

  // Press-level model: settled state (0 stopped, 2 playing, 3 paused) and track id.
  int m_st, m_id, m_restart;

  task automatic model_op(input int op);
    m_restart = 0;
    case (op)
      0: begin
        if (m_st == 0) begin m_st = 2; m_restart = 1; end
        else if (m_st == 2) m_st = 3;
        else m_st = 2;
      end
      1, 2: begin
        m_id = (op == 1) ? (m_id + 1) % N : (m_id + N - 1) % N;
        if (m_st != 0) begin m_st = 2; m_restart = 1; end
      end
      default: begin
        if (m_st == 2) begin m_id = (m_id + 1) % N; m_restart = 1; end
      end
    endcase
  endtask

  int base, n, sid, op;

  initial begin
    tick(2);
    rst = 1'b1;
    tick(1);
    chk_outs("reset", 0, 0, 0);
    tick(15);
    chk_outs("idle", 0, 0, 0);

    // Wrap-around while stopped
    press(2); chk_outs("prev_wrap", 0, 7, 0);
    press(1); chk_outs("next_wrap", 0, 0, 0);
    press(1); press(1); press(1); chk_outs("next3", 0, 3, 0);

    // Event latency for a clean hold
    sid = music_id;
    btn_next = 1'b1;
    n = 0;
    while (music_id == 3'(sid) && n < 50) begin tick(1); n++; end
    chk("latency", 32'(n), 32'(D + 4));
    tick(10);
    chk("hold_once", 32'(music_id), 32'd4);
    btn_next = 1'b0;
    tick(20);

    // Bounce rejection, then one event from the steady level
    for (int k = 0; k < 40; k++) begin
      btn_next = ~k[1];
      tick(1);
    end
    chk("bounce_none", 32'(music_id), 32'd4);
    btn_next = 1'b1;
    n = 0;
    while (music_id == 3'd4 && n < 50) begin tick(1); n++; end
    chk("bounce_latency", 32'(n), 32'(D + 4));
    tick(20);
    chk("bounce_once", 32'(music_id), 32'd5);
    btn_next = 1'b0;
    tick(20);

    // Play / pause / resume
    base = low_total; press(0);
    chk("play_pulse", 32'(low_total - base), 32'(R));
    chk_outs("play", 2, 5, 1);
    base = low_total; press(0);
    chk("pause_pulse", 32'(low_total - base), 32'd0);
    chk_outs("pause", 3, 5, 0);
    base = low_total; press(0);
    chk("resume_pulse", 32'(low_total - base), 32'd0);
    chk_outs("resume", 2, 5, 1);

    // Track change while playing, then auto-next
    press(1); press(1);
    chk_outs("at7", 2, 7, 1);
    base = low_total; press(1);
    chk("wrap_pulse", 32'(low_total - base), 32'(R));
    chk_outs("play_wrap", 2, 0, 1);
    base = low_total; pulse_end();
    chk("auto_pulse", 32'(low_total - base), 32'(R));
    chk_outs("auto_next", 2, 1, 1);

    // track_end in the same cycle the prev event reaches the FSM
    base = low_total;
    btn_prev = 1'b1;
    tick(D + 3);
    track_end = 1'b1;
    tick(1);
    track_end = 1'b0;
    tick(5);
    btn_prev = 1'b0;
    tick(20);
    chk("te_vs_prev_pulse", 32'(low_total - base), 32'(R));
    chk_outs("te_vs_prev", 2, 2, 1);

    // next event arrives while the prev-triggered restart is running
    btn_prev = 1'b1;
    tick(1);
    btn_next = 1'b1;
    tick(10);
    btn_prev = 1'b0;
    btn_next = 1'b0;
    tick(20);
    chk_outs("next_in_restart", 2, 1, 1);

    // Reset in the middle of a restart
    btn_next = 1'b1;
    n = 0;
    while (player_rst_n && n < 40) begin tick(1); n++; end
    chk("restart_seen", 32'(player_rst_n), 32'd0);
    rst = 1'b0;
    btn_next = 1'b0;
    tick(1);
    chk("mid_rst.rst_n", 32'(player_rst_n), 32'd1);
    chk("mid_rst.start", 32'(start), 32'd0);
    chk("mid_rst.id", 32'(music_id), 32'd0);
    chk("mid_rst.state", 32'(state_o), 32'd0);
    tick(1);
    rst = 1'b1;
    tick(20);
    chk_outs("after_rst", 0, 0, 0);

    // Random press sequence against the model
    m_st = 0;
    m_id = 0;
    for (int t = 0; t < 25; t++) begin
      op = $urandom_range(0, 3);
      model_op(op);
      base = low_total;
      if (op == 3) pulse_end();
      else press(op);
      chk("rnd_pulse", 32'(low_total - base), 32'(m_restart * R));
      chk_outs("rnd", m_st, m_id, (m_st == 2) ? 1 : 0);
    end

    chk("rst_n_outside_restart", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
